// File: rtl/etapa_fetch_if.sv
// Fetch-stage bus bundle: redirect/stall controls, instruction-memory port, IF/ID outputs.
// Latency: n/a (wires only). Backpressure: stall and imem_ready gate the fetch stage.
// Ports: master = fetch stage (drives imem_addr and IF/ID fields); slave = surrounding pipeline/memory.
interface etapa_fetch_if #(
  parameter int WIDTH    = 32,
  parameter int SIZE_INS = 6
) ();
  logic                stall;
  logic                branch_taken;
  logic [WIDTH-1:0]    branch_target;
  logic [WIDTH-1:0]    imem_addr;
  logic [WIDTH-1:0]    imem_data;
  logic                imem_ready;
  logic [WIDTH-1:0]    if_id_pc4;
  logic [WIDTH-1:0]    if_id_instr;
  logic                if_id_valid;
  logic [SIZE_INS-1:0] opcode;

  modport master (
    input  stall, branch_taken, branch_target, imem_data, imem_ready,
    output imem_addr, if_id_pc4, if_id_instr, if_id_valid, opcode
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data, imem_ready,
    input  imem_addr, if_id_pc4, if_id_instr, if_id_valid, opcode
  );
endinterface

// File: rtl/etapa_fetch.sv
// MIPS instruction fetch: PC register, imem address, IF/ID pipeline register, opcode to control.
// Latency: word at pc enters IF/ID one edge after imem_ready=1 with no stall/branch.
// Backpressure: branch flushes (highest), stall holds everything, imem_ready=0 holds pc and inserts a bubble.
// Ports: clk, rst_n (async active-low); bus (etapa_fetch_if.master) carries controls, imem port, IF/ID outputs.
module etapa_fetch #(
  parameter int               WIDTH    = 32,
  parameter int               SIZE_INS = 6,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  etapa_fetch_if.master   bus
);

  logic [WIDTH-1:0] pcReg;
  logic [WIDTH-1:0] pcPlus4;
  logic [WIDTH-1:0] alignedTarget;
  logic [WIDTH-1:0] ifIdPc4;
  logic [WIDTH-1:0] ifIdInstr;
  logic             ifIdValid;

  // Wraps modulo 2^WIDTH by construction of the adder width.
  assign pcPlus4 = pcReg + WIDTH'(4);

  // Misaligned redirects are silently word-aligned.
  assign alignedTarget = bus.branch_target & ~WIDTH'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg     <= RESET_PC;
      ifIdPc4   <= '0;
      ifIdInstr <= '0;
      ifIdValid <= 1'b0;
    end else if (bus.branch_taken) begin
      // Flush even when stalled so the held consumer sees a bubble next cycle.
      pcReg     <= alignedTarget;
      ifIdPc4   <= '0;
      ifIdInstr <= '0;
      ifIdValid <= 1'b0;
    end else if (bus.stall) begin
      pcReg     <= pcReg;
    end else if (!bus.imem_ready) begin
      // Memory wait state: refetch same pc, push an all-zero (sll $0) bubble.
      ifIdPc4   <= '0;
      ifIdInstr <= '0;
      ifIdValid <= 1'b0;
    end else begin
      pcReg     <= pcPlus4;
      ifIdPc4   <= pcPlus4;
      ifIdInstr <= bus.imem_data;
      ifIdValid <= 1'b1;
    end
  end

  assign bus.imem_addr   = pcReg;
  assign bus.if_id_pc4   = ifIdPc4;
  assign bus.if_id_instr = ifIdInstr;
  assign bus.if_id_valid = ifIdValid;
  assign bus.opcode      = ifIdInstr[WIDTH-1:WIDTH-SIZE_INS];

endmodule
